// File: rtl/banana_fire_scheduler.sv
// Alien banana launch scheduler: picks a live column and a free mover slot each eligible frame.
// Optional build macro BANANA_LFSR_COL_EN: start the column scan from an LFSR instead of round-robin.
module banana_fire_scheduler #(
    parameter int          NUM_SLOTS       = 4,
    parameter int          NUM_COLS        = 8,
    parameter int          COOLDOWN_FRAMES = 30,
    parameter int          MIN_COOLDOWN    = 8,
    parameter int          ACK_TIMEOUT     = 4,
    parameter int          COL_PITCH       = 64,
    parameter int          X_OFFSET        = 24,
    parameter int          Y_OFFSET        = 16,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic                   enable,
    input  logic [3:0]             level,
    input  logic [NUM_COLS-1:0]    col_alive,
    input  logic [NUM_COLS*11-1:0] col_bottom_y,
    input  logic [NUM_SLOTS-1:0]   slot_active,
    output logic [NUM_SLOTS-1:0]   appear,
    output logic [10:0]            fire_x,
    output logic [10:0]            fire_y,
    output logic                   busy
);

    localparam int COL_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int TMO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [7:0]       CD_BASE  = 8'(COOLDOWN_FRAMES);
    localparam logic [7:0]       CD_MIN   = 8'(MIN_COOLDOWN);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COOLDOWN,
        S_SELECT_COL,
        S_SELECT_SLOT,
        S_WAIT_ACK
    } state_t;

    state_t              state, state_d;
    logic [7:0]          cnt, cnt_d;
    logic [COL_W-1:0]    sel_col, sel_col_d, start_col, col_pick, col_inc;
    logic [SLOT_W-1:0]   sel_slot, sel_slot_d, rr_slot, rr_slot_d, slot_pick, slot_inc;
    logic [TMO_W-1:0]    tmo, tmo_d;
    logic [NUM_SLOTS-1:0] appear_d, free_slots;
    logic [10:0]         fire_x_d, fire_y_d;
    logic                col_found, slot_found, launch_ack;
    logic [7:0]          level_x2, cd_raw, cd;
    logic [10:0]         bottom_y [NUM_COLS];

    function automatic int wrap_idx(input int base, input int ofs, input int n);
        int sum;
        sum = base + ofs;
        return (sum >= n) ? sum - n : sum;
    endfunction

    for (genvar g = 0; g < NUM_COLS; g++) begin : g_unpack_y
        assign bottom_y[g] = col_bottom_y[11*g +: 11];
    end

    // Saturating subtract keeps high levels from wrapping to a huge cooldown.
    assign level_x2 = {3'b000, level, 1'b0};
    assign cd_raw   = (CD_BASE > level_x2) ? CD_BASE - level_x2 : 8'd0;
    assign cd       = (cd_raw < CD_MIN) ? CD_MIN : cd_raw;

    assign free_slots = ~slot_active;
    assign launch_ack = enable && (state == S_WAIT_ACK) && slot_active[sel_slot];
    assign col_inc    = (sel_col == COL_W'(NUM_COLS - 1)) ? '0 : sel_col + COL_W'(1);
    assign slot_inc   = (sel_slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : sel_slot + SLOT_W'(1);
    assign busy       = (state == S_SELECT_COL) || (state == S_SELECT_SLOT) || (state == S_WAIT_ACK);

`ifdef BANANA_LFSR_COL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign start_col = COL_W'(32'(lfsr[3:0]) % NUM_COLS);
`else
    logic [COL_W-1:0] rr_col;

    always_ff @(posedge clk) begin
        if (reset || !enable) rr_col <= '0;
        else if (launch_ack)  rr_col <= col_inc;
    end

    assign start_col = rr_col;
`endif

    always_comb begin
        col_found = 1'b0;
        col_pick  = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (!col_found && col_alive[COL_W'(wrap_idx(int'(start_col), i, NUM_COLS))]) begin
                col_found = 1'b1;
                col_pick  = COL_W'(wrap_idx(int'(start_col), i, NUM_COLS));
            end
        end
    end

    always_comb begin
        slot_found = 1'b0;
        slot_pick  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!slot_found && free_slots[SLOT_W'(wrap_idx(int'(rr_slot), i, NUM_SLOTS))]) begin
                slot_found = 1'b1;
                slot_pick  = SLOT_W'(wrap_idx(int'(rr_slot), i, NUM_SLOTS));
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        sel_col_d  = sel_col;
        sel_slot_d = sel_slot;
        rr_slot_d  = rr_slot;
        tmo_d      = tmo;
        appear_d   = appear;
        fire_x_d   = fire_x;
        fire_y_d   = fire_y;

        if (!enable) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            rr_slot_d = '0;
            tmo_d     = '0;
            appear_d  = '0;
            fire_x_d  = '0;
            fire_y_d  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt_d   = cd;
                    state_d = S_COOLDOWN;
                end
                S_COOLDOWN: begin
                    if (startOfFrame) begin
                        if (cnt == 8'd0) state_d = S_SELECT_COL;
                        else             cnt_d   = cnt - 8'd1;
                    end
                end
                S_SELECT_COL: begin
                    if (!col_found) begin
                        cnt_d   = cd;
                        state_d = S_COOLDOWN;
                    end else begin
                        sel_col_d = col_pick;
                        state_d   = S_SELECT_SLOT;
                    end
                end
                S_SELECT_SLOT: begin
                    if (!slot_found) begin
                        // All movers busy: retry on the very next frame.
                        cnt_d   = '0;
                        state_d = S_COOLDOWN;
                    end else begin
                        sel_slot_d = slot_pick;
                        fire_x_d   = 11'(int'(sel_col) * COL_PITCH + X_OFFSET);
                        fire_y_d   = bottom_y[sel_col] + 11'(Y_OFFSET);
                        appear_d   = NUM_SLOTS'(1) << slot_pick;
                        tmo_d      = '0;
                        state_d    = S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (launch_ack) begin
                        appear_d  = '0;
                        rr_slot_d = slot_inc;
                        cnt_d     = cd;
                        state_d   = S_COOLDOWN;
                    end else if (startOfFrame) begin
                        if (tmo == TMO_LAST) begin
                            appear_d = '0;
                            cnt_d    = '0;
                            state_d  = S_COOLDOWN;
                        end else begin
                            tmo_d = tmo + TMO_W'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sel_col  <= '0;
            sel_slot <= '0;
            rr_slot  <= '0;
            tmo      <= '0;
            appear   <= '0;
            fire_x   <= '0;
            fire_y   <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            sel_col  <= sel_col_d;
            sel_slot <= sel_slot_d;
            rr_slot  <= rr_slot_d;
            tmo      <= tmo_d;
            appear   <= appear_d;
            fire_x   <= fire_x_d;
            fire_y   <= fire_y_d;
        end
    end

endmodule
